// File: rtl/reg_dump_if.sv
//------------------------------------------------------------------------------
// reg_dump_if
// Bundles the register-file read port and the dumped-word output handshake
// of reg_dump_reader.
//
// Signals
//   rf_read_reg  : register index presented to the register file read port
//   rf_read_data : register file data, valid one clock edge after the index
//   out_valid    : out_data/out_index hold a dumped word
//   out_ready    : downstream accepts the word on out_valid && out_ready
//   out_data     : dumped register value
//   out_index    : index of the register held in out_data
//
// Modports
//   master : the dump reader (drives the read index and the output word)
//   slave  : the environment (register file and downstream consumer)
//------------------------------------------------------------------------------
interface reg_dump_if #(
    parameter int data_size = 32,
    parameter int addr_size = 4
) ();

    logic [addr_size-1:0] rf_read_reg;
    logic [data_size-1:0] rf_read_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [data_size-1:0] out_data;
    logic [addr_size-1:0] out_index;

    modport master (
        output rf_read_reg,
        input  rf_read_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index
    );

    modport slave (
        input  rf_read_reg,
        output rf_read_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index
    );

endinterface

// File: rtl/reg_dump_reader.sv
//------------------------------------------------------------------------------
// reg_dump_reader
// Walks a register file from index 0 to regs_count-1 and streams every value
// out through a valid/ready handshake, one word per register. Each word takes
// three states: ISSUE (present the index), CAPTURE (latch the read data one
// edge later) and SEND (hold the word until it is accepted). A one-cycle done
// pulse follows acceptance of the last word.
//
// Ports
//   clk   : single clock, all state changes on its rising edge
//   rst   : synchronous, active-high reset
//   start : request a full dump, only looked at while idle
//   abort : drop an active dump and return to idle at the next edge
//   busy  : high in every state except IDLE
//   done  : one-cycle pulse after the last word has been accepted
//   bus   : register-file read port and output word handshake (master side)
//
// All outputs are registered: each transition loads the output values that
// belong to the destination state, so outputs always describe the current
// state with no combinational path from the inputs.
//------------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int data_size  = 32,
    parameter int regs_count = 16,
    parameter int addr_size  = $clog2(regs_count)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    reg_dump_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        FINISH
    } state_t;

    // The last index is compared directly so the counter stops at
    // regs_count-1 and never relies on wrapping, which also covers register
    // counts that are not a power of two.
    localparam logic [addr_size-1:0] last_idx  = addr_size'(regs_count - 1);
    localparam logic [addr_size-1:0] zero_idx  = '0;
    localparam logic [data_size-1:0] zero_word = '0;

    state_t               state;
    logic [addr_size-1:0] idx;

    // NOTE: every register here is assigned with <= so all of them update
    // together from the values they held before the edge; a blocking '='
    // would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronous reset wins over start and abort because it is
            // tested first.
            state           <= IDLE;
            idx             <= zero_idx;
            bus.rf_read_reg <= zero_idx;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= zero_word;
            bus.out_index   <= zero_idx;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Abort drops whatever is in flight, including a word sitting in
            // SEND. A word accepted on this same edge has already been taken
            // by the consumer, so nothing more is needed for it.
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx             <= zero_idx;
                        bus.rf_read_reg <= zero_idx;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end

                ISSUE: begin
                    // rf_read_reg already carries idx; the register file
                    // returns the data on the coming edge.
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    // Only place out_data/out_index are loaded, so they stay
                    // stable for however long SEND has to wait.
                    bus.out_data  <= bus.rf_read_data;
                    bus.out_index <= idx;
                    bus.out_valid <= 1'b1;
                    state         <= SEND;
                end

                SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (idx == last_idx) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx             <= idx + addr_size'(1);
                            bus.rf_read_reg <= idx + addr_size'(1);
                            state           <= ISSUE;
                        end
                    end
                end

                FINISH: begin
                    // A start seen here is deliberately ignored; a new dump
                    // needs a fresh request once IDLE has been reached.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter data_size, default 32, width of one register word.
REQ-002 Parameter regs_count, default 16, number of registers dumped.
REQ-003 Parameter addr_size, default $clog2(regs_count), register index width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a full dump; sampled only in IDLE.
REQ-007 abort  input  1  terminate an active dump at the next edge.
REQ-008 rf_read_reg  output  addr_size  register index driven to the register file read port.
REQ-009 rf_read_data  input  data_size  register file read data, valid one clock edge after rf_read_reg is presented.
REQ-010 out_valid  output  1  out_data/out_index hold a dumped word.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid && out_ready at a rising edge.
REQ-012 out_data  output  data_size  dumped register value.
REQ-013 out_index  output  addr_size  index of the register in out_data.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, SEND and FINISH.
REQ-017 IDLE: on start=1, idx := 0 and next state = ISSUE; otherwise stay.
REQ-018 ISSUE: rf_read_reg = idx; next state = CAPTURE unconditionally.
REQ-019 CAPTURE: rf_read_reg is held at idx; rf_read_data is latched into out_data and idx into out_index; next state = SEND.
REQ-020 SEND: out_valid = 1, and out_data/out_index are stable until accepted.
REQ-021 SEND with acceptance and idx = regs_count-1: next state = FINISH.
REQ-022 SEND with acceptance and idx < regs_count-1: idx := idx+1 and next state = ISSUE.
REQ-023 SEND without acceptance: stay in SEND, with no change to any output.
REQ-024 FINISH: done = 1 for exactly one cycle; next state = IDLE; a start seen in FINISH is ignored.
REQ-025 Minimum latency: start edge to first out_valid is 3 cycles; consecutive accepted words are 3 cycles apart.
REQ-026 Full dump with out_ready tied high: busy for 3*regs_count+1 cycles; done is high in the last busy cycle.
REQ-027 idx SHALL count 0..regs_count-1 only and never wrap; regs_count need not be a power of two.
REQ-028 start while busy SHALL be ignored; no restart and no idx change.
REQ-029 abort in any non-IDLE state SHALL force IDLE at the next edge.
REQ-030 On abort, out_valid and busy are 0 the next cycle, done is not pulsed, and a word in SEND is discarded.
REQ-031 abort and an acceptance in the same cycle: the word counts as transferred and abort still wins.
REQ-032 abort and start together in IDLE: start wins, because abort has no effect in IDLE.
REQ-033 The dumped value of the PC register (index regs_count-1) is whatever the register file returns at its capture edge; no special handling.
REQ-034 out_data and out_index SHALL change only in CAPTURE or on reset.

Reset
REQ-035 rst=1 at an edge SHALL force state IDLE, idx = 0, and all outputs to 0 (rf_read_reg, out_valid, out_data, out_index, busy, done).
REQ-036 rst SHALL override start and abort.
REQ-037 rst mid-dump SHALL discard progress; the next start dumps again from index 0.

Verification
REQ-038 Preload R0..R14 = 0x100+i, out_ready=1, start pulse -> 16 words with out_index 0..15 and out_data 0x100..0x10E then the PC value; done at cycle 49 after start; busy falls at cycle 50.
REQ-039 out_ready=0 for 5 cycles while the word with index 3 is in SEND -> out_valid held with out_data/out_index stable for all 5 cycles; index 4 is issued only after acceptance.
REQ-040 abort asserted in SEND at index 7 -> next cycle IDLE, busy=0, out_valid=0, no done; a following start emits index 0 first.
REQ-041 rst asserted in CAPTURE at index 10 -> next cycle all outputs 0; start pulses held during rst produce no activity.
REQ-042 start re-pulsed at index 2 and again in FINISH -> dump unaffected and exactly one done; the FSM returns to IDLE and stays there.
REQ-043 regs_count=5 (non-power-of-two) -> indices 0..4 only, done after index 4, no index 5 or wrap observed.
